// File: rtl/bit_4_full_adder.sv
// bit_4_full_adder: registered 4-bit ripple-carry adder with valid strobe; zero/ovf flags exist only when BIT_4_FA_FLAGS_EN is defined
module bit_4_fa_cell (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module bit_4_full_adder (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       cout,
    output logic       out_valid
`ifdef BIT_4_FA_FLAGS_EN
    ,
    output logic       zero,
    output logic       ovf
`endif
);
    logic [4:0] c;
    logic [3:0] sum;
    assign c[0] = cin;
    for (genvar i = 0; i < 4; i++) begin : g_cell
        bit_4_fa_cell u_cell (
            .a  (a[i]),
            .b  (b[i]),
            .ci (c[i]),
            .s  (sum[i]),
            .co (c[i+1])
        );
    end
    // load sum/carry on accepted operations; valid follows the strobe every edge
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s         <= '0;
            cout      <= 1'b0;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                s    <= sum;
                cout <= c[4];
            end
        end
    end
`ifdef BIT_4_FA_FLAGS_EN
    // flags track the registered sum; zero resets high because s resets to 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            zero <= 1'b1;
            ovf  <= 1'b0;
        end else if (in_valid) begin
            zero <= (sum == 4'd0);
            ovf  <= (a[3] == b[3]) && (sum[3] != a[3]);
        end
    end
`endif
endmodule

// File: tb/tb_bit_4_full_adder.sv
// tb_bit_4_full_adder: randomized and directed checks of bit_4_full_adder against an arithmetic model
module tb_bit_4_full_adder;
    logic       clk = 1'b0, clk_en = 1'b0, rst = 1'b0, in_valid = 1'b0, cin = 1'b0;
    logic [3:0] a = '0, b = '0, s;
    logic       cout, out_valid;
`ifdef BIT_4_FA_FLAGS_EN
    logic       zero, ovf;
`endif
    int         checks = 0, fails = 0;
    logic [3:0] m_s;
    logic       m_c, m_z, m_o;

    always #5 if (clk_en) clk = ~clk;

    bit_4_full_adder dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .s         (s),
        .cout      (cout),
        .out_valid (out_valid)
`ifdef BIT_4_FA_FLAGS_EN
        ,
        .zero      (zero),
        .ovf       (ovf)
`endif
    );

    task automatic model_reset();
        m_s = '0; m_c = 1'b0; m_z = 1'b1; m_o = 1'b0;
    endtask

    task automatic cycle(input logic v, input logic [3:0] ta, input logic [3:0] tb, input logic tc);
        int u, sa, sb, sv;
        @(negedge clk);
        in_valid = v; a = ta; b = tb; cin = tc;
        @(posedge clk);
        #1;
        if (v) begin
            u  = int'(ta) + int'(tb) + int'(tc);
            sa = ta > 7 ? int'(ta) - 16 : int'(ta);
            sb = tb > 7 ? int'(tb) - 16 : int'(tb);
            sv = sa + sb + int'(tc);
            m_s = 4'(u % 16);
            m_c = u > 15;
            m_z = (u % 16) == 0;
            m_o = sv > 7 || sv < -8;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        model_reset();
        #2;
        checks++;
        if ({out_valid, cout, s} !== 6'b000000) begin
            fails++;
            $display("FAIL reset_async: got v=%b c=%b s=%b want 0 0 0000", out_valid, cout, s);
        end
`ifdef BIT_4_FA_FLAGS_EN
        checks++;
        if ({zero, ovf} !== 2'b10) begin
            fails++;
            $display("FAIL reset_flags: got z=%b o=%b want 1 0", zero, ovf);
        end
`endif
        clk_en = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            cycle(1'b0, 4'hf, 4'hf, 1'b1);
            checks++;
            if ({out_valid, cout, s} !== 6'b000000) begin
                fails++;
                $display("FAIL reset_idle%0d: got v=%b c=%b s=%b want 0 0 0000", k, out_valid, cout, s);
            end
        end
    endtask

    task automatic test_zero();
        cycle(1'b1, 4'h0, 4'h0, 1'b0);
        checks++;
        if ({out_valid, cout, s} !== 6'b100000) begin
            fails++;
            $display("FAIL zero_add: got v=%b c=%b s=%b want 1 0 0000", out_valid, cout, s);
        end
`ifdef BIT_4_FA_FLAGS_EN
        checks++;
        if ({zero, ovf} !== 2'b10) begin
            fails++;
            $display("FAIL zero_flags: got z=%b o=%b want 1 0", zero, ovf);
        end
`endif
    endtask

    task automatic run_table(input string name, input logic [12:0] vec [3]);
        for (int k = 0; k < 3; k++) begin
            cycle(1'b1, vec[k][12:9], vec[k][8:5], vec[k][4]);
            checks++;
            if ({out_valid, cout, s} !== {1'b1, vec[k][3:0] == vec[k][3:0] ? {m_c, m_s} : 5'b0}
                || {cout, s} !== {(int'(vec[k][12:9]) + int'(vec[k][8:5]) + int'(vec[k][4])) > 15, vec[k][3:0]}) begin
                fails++;
                $display("FAIL %s%0d: got v=%b c=%b s=%b want 1 %b %b", name, k, out_valid, cout, s, m_c, vec[k][3:0]);
            end
`ifdef BIT_4_FA_FLAGS_EN
            checks++;
            if ({zero, ovf} !== {m_z, m_o}) begin
                fails++;
                $display("FAIL %s%0d_flags: got z=%b o=%b want %b %b", name, k, zero, ovf, m_z, m_o);
            end
`endif
        end
    endtask

    task automatic test_back_to_back();
        logic [12:0] vec [3];
        vec = '{{4'b0001, 4'b0010, 1'b0, 4'b0011},
                {4'b1110, 4'b0110, 1'b0, 4'b0100},
                {4'b1111, 4'b1111, 1'b0, 4'b1110}};
        run_table("b2b", vec);
    endtask

    task automatic test_carry();
        logic [12:0] vec [3];
        vec = '{{4'b1111, 4'b1111, 1'b1, 4'b1111},
                {4'b1111, 4'b0000, 1'b1, 4'b0000},
                {4'b0111, 4'b0001, 1'b0, 4'b1000}};
        run_table("carry", vec);
`ifdef BIT_4_FA_FLAGS_EN
        checks++;
        if (ovf !== 1'b1) begin
            fails++;
            $display("FAIL carry_ovf: got o=%b want 1", ovf);
        end
`endif
    endtask

    task automatic test_reset_inflight();
        @(negedge clk);
        in_valid = 1'b1; a = 4'b0101; b = 4'b0101; cin = 1'b0;
        #2;
        rst = 1'b1;
        model_reset();
        #1;
        checks++;
        if ({out_valid, cout, s} !== 6'b000000) begin
            fails++;
            $display("FAIL inflight_rst: got v=%b c=%b s=%b want 0 0 0000", out_valid, cout, s);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({out_valid, s} !== 5'b00000) begin
            fails++;
            $display("FAIL inflight_held: got v=%b s=%b want 0 0000", out_valid, s);
        end
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b1, 4'b0011, 4'b0100, 1'b0);
        checks++;
        if ({out_valid, cout, s} !== 6'b100111) begin
            fails++;
            $display("FAIL inflight_after: got v=%b c=%b s=%b want 1 0 0111", out_valid, cout, s);
        end
    endtask

    task automatic test_exhaustive();
        for (int k = 0; k < 512; k++) begin
            logic [8:0] v;
            v = 9'(k);
            cycle(1'b1, v[8:5], v[4:1], v[0]);
            checks++;
            if ({out_valid, cout, s} !== {1'b1, 5'(int'(v[8:5]) + int'(v[4:1]) + int'(v[0]))}) begin
                fails++;
                $display("FAIL exhaustive: a=%h b=%h cin=%b got v=%b c=%b s=%h", v[8:5], v[4:1], v[0], out_valid, cout, s);
            end
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 200; k++) begin
            logic v;
            v = 1'($urandom_range(0, 2) != 0);
            cycle(v, 4'($urandom), 4'($urandom), 1'($urandom));
            checks++;
            if ({out_valid, cout, s} !== {v, m_c, m_s}) begin
                fails++;
                $display("FAIL random%0d: got v=%b c=%b s=%h want %b %b %h", k, out_valid, cout, s, v, m_c, m_s);
            end
`ifdef BIT_4_FA_FLAGS_EN
            checks++;
            if ({zero, ovf} !== {m_z, m_o}) begin
                fails++;
                $display("FAIL random%0d_flags: got z=%b o=%b want %b %b", k, zero, ovf, m_z, m_o);
            end
`endif
        end
    endtask

    initial begin
        test_reset();
        test_zero();
        test_back_to_back();
        test_carry();
        test_reset_inflight();
        test_exhaustive();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule

// File: doc/bit_4_full_adder.md
# bit_4_full_adder

Registered 4-bit ripple-carry adder: adds two 4-bit operands and a carry-in, and returns a 4-bit sum and a carry-out one clock after the operands are accepted. It is the arithmetic leaf cell of the ALU datapath. It is built from four chained 1-bit full-adder cells so that carry propagation is explicit and can be checked bit by bit. A valid strobe travels alongside the data so that upstream ALU control can issue an operation on any cycle.

## Interface
Parameters: none (width fixed at 4).

Ports:
- clk  input  1  single clock; all state updates on the rising edge
- rst  input  1  reset, asynchronous, active-high
- in_valid  input  1  a, b, cin are sampled on this clock edge
- a  input  4  operand A, unsigned
- b  input  4  operand B, unsigned
- cin  input  1  carry into bit 0
- s  output  4  registered sum, a + b + cin mod 16
- cout  output  1  registered carry out of bit 3
- out_valid  output  1  s and cout hold the result of the previous accepted operation
- zero  output  1  (only with BIT_4_FA_FLAGS_EN) registered; 1 when s == 0
- ovf  output  1  (only with BIT_4_FA_FLAGS_EN) registered two's-complement overflow

## Operation
- Combinational core: four full-adder cells. Bit i computes sum_i = a[i]^b[i]^c_i and c_{i+1} = a[i]&b[i] | c_i&(a[i]^b[i]). c_0 = cin, cout = c_4.
- Full 5-bit result: {cout, s} = a + b + cin, range 0..31. There are no other wrap or saturation rules.
- When in_valid=1 at a rising edge, s, cout (and zero, ovf) load the core result and out_valid is set to 1.
- When in_valid=0 at a rising edge, out_valid is cleared to 0 and s, cout, zero, ovf hold their previous values.
- ovf = (a[3] == b[3]) && (s[3] != a[3]), computed from the same operands.
- No backpressure. An accepted operation always completes, and back-to-back operations run at 1 per cycle.

## Timing
- Latency: 1 cycle from the sampling edge to the updated output. Throughput: 1 operation per cycle.
- While rst=1, independent of clk: s=0, cout=0, out_valid=0, zero=1, ovf=0.
- Reset asserted mid-operation drops the in-flight result. The first edge after rst deasserts samples inputs normally.
- Inputs changing between edges have no effect on the outputs, which are registered only.
- The carry chain is 4 cells deep combinationally and must close timing within one clk period.

## Configuration
- BIT_4_FA_FLAGS_EN
  - Defined: the zero and ovf ports and their registers exist and behave as above.
  - Undefined: those ports and registers are absent. s, cout and out_valid behave identically to the flags-enabled build.

## Test plan
- Reset: assert rst with no clock running -> s=0, cout=0, out_valid=0 immediately. Release rst, then in_valid=0 for 2 edges -> outputs unchanged.
- Stimulus a=0000, b=0000, cin=0 at edge N -> at N+1: s=0000, cout=0, out_valid=1, zero=1, ovf=0.
- Back-to-back operations:
  - 0001+0010+0 -> s=0011, cout=0
  - 1110+0110+0 -> s=0100, cout=1, ovf=0
  - 1111+1111+0 -> s=1110, cout=1
  - Each result appears exactly one cycle after it is issued.
- Carry-in and full ripple:
  - 1111+1111+1 -> s=1111, cout=1
  - 1111+0000+1 -> s=0000, cout=1, zero=1
  - 0111+0001+0 -> s=1000, ovf=1
- Reset in flight: issue 0101+0101 and assert rst before the next edge -> s=0, out_valid=0. After release, a new 0011+0100 -> s=0111.
- Exhaustive check: all 512 (a, b, cin) combinations, one per cycle -> {cout, s} == a+b+cin on the following cycle.
